pp_mul_pipe_rv: RTL and testbench
=================================

Name: pp_mul_pipe_rv

Overview:
- Parametrised successor to the fixed 12x12 unsigned, 4-stage, ce-gated DSP multiplier in the pp_pipeline_accel datapath.
- Adds:
  - configurable operand, product and depth widths
  - per-transaction signedness
  - rounding right-shift
  - valid/ready flow control in place of a bare ce
- Used by pre-processing kernels for scale/normalise products feeding AXI-Stream stages.

Parameters:
- A_WIDTH, 12, width of operand a (2..27)
- B_WIDTH, 12, width of operand b (2..18)
- P_WIDTH, 24, output width (1..A_WIDTH+B_WIDTH)
- SHIFT, 0, result right-shift with round-half-up (0..A_WIDTH+B_WIDTH-1)
- NUM_STAGE, 4, input-accept to out_valid latency in cycles (>=3)

Ports:
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_a  in  A_WIDTH  operand a
- in_b  in  B_WIDTH  operand b
- in_mode  in  2  bit0: a signed; bit1: b signed
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_p  out  P_WIDTH  result

Behaviour:
- Reset, asserted asynchronously at any time including mid-stream:
  - all stage valid bits clear; out_valid=0; out_p=0; in_ready=1 after release
  - in-flight beats discarded
  - data registers need not be reset, but out_p must read 0 at reset
- Global advance: adv = !out_valid || out_ready. Every stage register loads only when adv=1. in_ready = adv, purely combinational from out_valid/out_ready; no in_valid dependency.
- Accept when in_valid && in_ready.
- Stage 1 registers in_a, in_b, in_mode and a valid bit. A bubble (in_valid=0 while adv) shifts in valid=0.
- Stage 2 computes the full product:
  - each operand extended by 1 bit, sign- or zero-extended per its in_mode bit
  - product is a signed value of width A_WIDTH+B_WIDTH+2
- Stages 3..NUM_STAGE-1 are pure delay; valid and mode travel alongside.
- Final stage (NUM_STAGE):
  - if SHIFT>0: add 2^(SHIFT-1), then arithmetic shift right by SHIFT
  - reduce to P_WIDTH per the optional feature
  - register into out_p/out_valid
- Latency is exactly NUM_STAGE cycles with out_ready held high: beat accepted at edge k gives out_valid=1 after edge k+NUM_STAGE-1.
- Throughput is 1 beat/cycle when unstalled.
- out_valid && !out_ready: whole pipe freezes, out_p stable, in_ready=0; no beat lost or duplicated.
- Bubbles advance, so out_valid=0 cycles while the pipe is non-empty are legal.
- Default reduction (wrap): out_p = low P_WIDTH bits of the shifted result.
- Mixed mode (one signed, one unsigned) is well-defined by the per-operand extension above.

Optional Feature:
- Macro: PP_MUL_PIPE_SAT_EN.
- Defined: final-stage reduction saturates.
  - Clamp range is signed [-2^(P_WIDTH-1), 2^(P_WIDTH-1)-1] if either in_mode bit is set, else unsigned [0, 2^P_WIDTH-1].
  - Adds sticky output sat_flag (1 bit), set when any delivered beat clamps, cleared only by reset.
- Undefined: wrap behaviour; sat_flag port absent.
- Latency identical in both builds.

Test Plan:
- Defaults, mode=00, a=0xFFF, b=0xFFF, out_ready=1 -> out_p=0xFFE001 exactly 4 cycles after accept; a=0, b=0x123 -> 0.
- mode=11, a=0x800 (-2048), b=0x001 -> out_p=0xFFF800; mode=01, a=0xFFF (-1), b=0xFFF (4095) -> out_p=0xFFF001.
- 16 back-to-back beats a=i, b=3; out_ready low for 5 cycles at beat 6 -> outputs 0,3,...,45 in order, none lost or duplicated; in_ready=0 and out_p stable while stalled.
- SHIFT=4, P_WIDTH=16, mode=00, a=0x0F8, b=0x001 -> (248+8)>>4=16; a=0x0F7 -> 15.
- PP_MUL_PIPE_SAT_EN with P_WIDTH=16, mode=11, a=0x7FF, b=0x7FF -> out_p=0x7FFF, sat_flag=1; without macro -> out_p=0xF001.
- Assert ap_rst_n low for 1 cycle with 3 beats in flight -> out_valid=0, out_p=0 immediately; no stale beat emerges afterward; next accepted beat appears after NUM_STAGE cycles.

Source files
------------

// File: rtl/pp_mul_pipe_rv.sv
`default_nettype none
// ============================================================================
// Module   : pp_mul_pipe_rv
// Purpose  : Parametrised pipelined multiplier with valid/ready flow control,
//            per-operand signedness, optional round-half-up right shift and
//            wrap (default) or saturating reduction to P_WIDTH.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   ap_clk     in   1        clock, rising edge
//   ap_rst_n   in   1        asynchronous active-low reset
//   in_valid   in   1        input beat valid
//   in_ready   out  1        beat can be accepted this cycle
//   in_a       in   A_WIDTH  operand a
//   in_b       in   B_WIDTH  operand b
//   in_mode    in   2        bit0: a signed, bit1: b signed
//   out_valid  out  1        result valid
//   out_ready  in   1        downstream accepts result
//   out_p      out  P_WIDTH  result
//   sat_flag   out  1        sticky clamp indicator (saturating build only)
// Build option:
//   PP_MUL_PIPE_SAT_EN  - defined: saturating reduction plus sat_flag port;
//                         undefined: low P_WIDTH bits of the result (wrap).
// ============================================================================
module pp_mul_pipe_rv #(
    parameter int A_WIDTH   = 12,
    parameter int B_WIDTH   = 12,
    parameter int P_WIDTH   = 24,
    parameter int SHIFT     = 0,
    parameter int NUM_STAGE = 4
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] in_a,
    input  logic [B_WIDTH-1:0] in_b,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [P_WIDTH-1:0] out_p
`ifdef PP_MUL_PIPE_SAT_EN
    ,
    output logic               sat_flag
`endif
);

    // Full signed product width: each operand carries one extension bit.
    localparam int C_PW  = A_WIDTH + B_WIDTH + 2;
    // Registers from stage 2 up to stage NUM_STAGE-1 form one delay line.
    localparam int C_DLY = NUM_STAGE - 2;

    // ------------------------------------------------------------------------
    // Flow control: the whole pipe moves together unless the output is held.
    // ------------------------------------------------------------------------
    logic w_adv;
    logic out_valid_q;

    assign w_adv     = !out_valid_q || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = out_valid_q;

    // ------------------------------------------------------------------------
    // Stage 1: operand capture. Data follows adv regardless of in_valid; the
    // valid bit marks bubbles.
    // ------------------------------------------------------------------------
    logic               s1_valid_q;
    logic [A_WIDTH-1:0] s1_a_q;
    logic [B_WIDTH-1:0] s1_b_q;
    logic [1:0]         s1_mode_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_valid_q <= 1'b0;
        end else if (w_adv) begin
            s1_valid_q <= in_valid;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (w_adv) begin
            s1_a_q    <= in_a;
            s1_b_q    <= in_b;
            s1_mode_q <= in_mode;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2 product: extending each operand by one bit (sign or zero) turns
    // every mode combination into a single signed x signed multiply.
    // ------------------------------------------------------------------------
    logic signed [A_WIDTH:0]  w_a_ext;
    logic signed [B_WIDTH:0]  w_b_ext;
    logic signed [C_PW-1:0]   w_prod;

    assign w_a_ext = {s1_mode_q[0] & s1_a_q[A_WIDTH-1], s1_a_q};
    assign w_b_ext = {s1_mode_q[1] & s1_b_q[B_WIDTH-1], s1_b_q};
    assign w_prod  = C_PW'(w_a_ext) * C_PW'(w_b_ext);

    // ------------------------------------------------------------------------
    // Delay line: index 0 is stage 2, index C_DLY-1 is stage NUM_STAGE-1.
    // ------------------------------------------------------------------------
    logic                   dly_v_q [C_DLY];
    logic signed [C_PW-1:0] dly_p_q [C_DLY];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < C_DLY; i++) begin
                dly_v_q[i] <= 1'b0;
            end
        end else if (w_adv) begin
            for (int i = C_DLY - 1; i > 0; i--) begin
                dly_v_q[i] <= dly_v_q[i-1];
            end
            dly_v_q[0] <= s1_valid_q;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (w_adv) begin
            for (int i = C_DLY - 1; i > 0; i--) begin
                dly_p_q[i] <= dly_p_q[i-1];
            end
            dly_p_q[0] <= w_prod;
        end
    end

    logic                   w_last_v;
    logic signed [C_PW-1:0] w_last_p;

    assign w_last_v = dly_v_q[C_DLY-1];
    assign w_last_p = dly_p_q[C_DLY-1];

    // ------------------------------------------------------------------------
    // Final stage: optional round-half-up arithmetic shift. The bias cannot
    // overflow because |product| < 2^(A_WIDTH+B_WIDTH) inside a C_PW-bit word.
    // ------------------------------------------------------------------------
    logic signed [C_PW-1:0] w_shifted;

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [C_PW-1:0] C_HALF = C_PW'(1) << (SHIFT - 1);
            assign w_shifted = (w_last_p + C_HALF) >>> SHIFT;
        end else begin : g_no_round
            assign w_shifted = w_last_p;
        end
    endgenerate

    logic [P_WIDTH-1:0] out_p_d;
    logic [P_WIDTH-1:0] out_p_q;

`ifdef PP_MUL_PIPE_SAT_EN
    // Mode only matters to the clamp, so it rides the delay line only here.
    logic [1:0] dly_m_q [C_DLY];

    always_ff @(posedge ap_clk) begin
        if (w_adv) begin
            for (int i = C_DLY - 1; i > 0; i--) begin
                dly_m_q[i] <= dly_m_q[i-1];
            end
            dly_m_q[0] <= s1_mode_q;
        end
    end

    localparam logic signed [C_PW-1:0] C_SMAX = (C_PW'(1) << (P_WIDTH - 1)) - C_PW'(1);
    localparam logic signed [C_PW-1:0] C_SMIN = ~C_SMAX;
    localparam logic signed [C_PW-1:0] C_UMAX = (C_PW'(1) << P_WIDTH) - C_PW'(1);

    logic w_clamp;
    logic sat_flag_q;
    logic sat_flag_d;

    always_comb begin
        out_p_d = P_WIDTH'(w_shifted);
        w_clamp = 1'b0;
        if (dly_m_q[C_DLY-1] != 2'b00) begin
            if (w_shifted > C_SMAX) begin
                out_p_d = P_WIDTH'(C_SMAX);
                w_clamp = 1'b1;
            end else if (w_shifted < C_SMIN) begin
                out_p_d = P_WIDTH'(C_SMIN);
                w_clamp = 1'b1;
            end
        end else if (w_shifted > C_UMAX) begin
            // Unsigned results are never negative, so only the top clamps.
            out_p_d = P_WIDTH'(C_UMAX);
            w_clamp = 1'b1;
        end
    end

    // A registered beat is always delivered unless reset intervenes, and
    // reset clears the flag anyway, so flag it as it enters the output stage.
    assign sat_flag_d = sat_flag_q | (w_adv & w_last_v & w_clamp);
    assign sat_flag   = sat_flag_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sat_flag_q <= 1'b0;
        end else begin
            sat_flag_q <= sat_flag_d;
        end
    end
`else
    assign out_p_d = P_WIDTH'(w_shifted);
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
        end else if (w_adv) begin
            out_valid_q <= w_last_v;
            out_p_q     <= out_p_d;
        end
    end

    assign out_p = out_p_q;

endmodule
`default_nettype wire

// File: tb/tb_pp_mul_pipe_rv.sv
`default_nettype none
// ============================================================================
// Module   : tb_pp_mul_pipe_rv
// Purpose  : Self-checking bench for pp_mul_pipe_rv. Three instances share one
//            stimulus stream: defaults (P=24), P=16 with SHIFT=4, and P=16
//            with SHIFT=0. A queue-based arithmetic model predicts every beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pp_mul_pipe_rv;

    localparam int NS = 4;

    logic        ap_clk    = 1'b0;
    logic        ap_rst_n  = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [11:0] in_a      = '0;
    logic [11:0] in_b      = '0;
    logic [1:0]  in_mode   = '0;

    logic        rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic [23:0] p0;
    logic [15:0] p1, p2;
`ifdef PP_MUL_PIPE_SAT_EN
    logic        sf0, sf1, sf2;
`endif

    always #5 ap_clk = ~ap_clk;

    pp_mul_pipe_rv #(.A_WIDTH(12), .B_WIDTH(12), .P_WIDTH(24), .SHIFT(0), .NUM_STAGE(NS)) dut0 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(ov0),
        .out_ready(out_ready), .out_p(p0)
`ifdef PP_MUL_PIPE_SAT_EN
        , .sat_flag(sf0)
`endif
    );

    pp_mul_pipe_rv #(.A_WIDTH(12), .B_WIDTH(12), .P_WIDTH(16), .SHIFT(4), .NUM_STAGE(NS)) dut1 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(ov1),
        .out_ready(out_ready), .out_p(p1)
`ifdef PP_MUL_PIPE_SAT_EN
        , .sat_flag(sf1)
`endif
    );

    pp_mul_pipe_rv #(.A_WIDTH(12), .B_WIDTH(12), .P_WIDTH(16), .SHIFT(0), .NUM_STAGE(NS)) dut2 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(ov2),
        .out_ready(out_ready), .out_p(p2)
`ifdef PP_MUL_PIPE_SAT_EN
        , .sat_flag(sf2)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout/unexpected required=event", name);
    endtask

    // Arithmetic reference: interpret operands, multiply, round, reduce.
    function automatic logic [63:0] mdl(input logic [11:0] a, input logic [11:0] b,
                                        input logic [1:0] m, input int sh, input int pw,
                                        output bit clamped);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (m[0] && a[11]) sa = sa - 4096;
        if (m[1] && b[11]) sb = sb - 4096;
        p = sa * sb;
        if (sh > 0) p = (p + (longint'(1) <<< (sh - 1))) >>> sh;
        clamped = 1'b0;
`ifdef PP_MUL_PIPE_SAT_EN
        begin
            longint lo, hi;
            if (m != 2'b00) begin
                hi = (longint'(1) <<< (pw - 1)) - 1;
                lo = -(longint'(1) <<< (pw - 1));
            end else begin
                hi = (longint'(1) <<< pw) - 1;
                lo = 0;
            end
            if (p > hi) begin p = hi; clamped = 1'b1; end
            else if (p < lo) begin p = lo; clamped = 1'b1; end
        end
`endif
        return 64'(p) & ((64'd1 << pw) - 64'd1);
    endfunction

    typedef struct {
        logic [23:0] e0;
        logic [15:0] e1;
        logic [15:0] e2;
        bit          c0, c1, c2;
    } beat_t;

    beat_t       q[$];
    logic [23:0] log0[$];
    int          acc_cnt    = 0;
    bit          prev_stall = 1'b0;
    logic [23:0] prev_p0    = '0;
    bit          esat0 = 1'b0, esat1 = 1'b0, esat2 = 1'b0;

    // Compare process: all handshakes are evaluated at the falling edge and
    // take effect at the following rising edge.
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            q.delete();
            prev_stall = 1'b0;
            esat0 = 1'b0; esat1 = 1'b0; esat2 = 1'b0;
            chk("rst_out_valid", {61'd0, ov0, ov1, ov2}, 64'd0);
            chk("rst_out_p", {8'd0, p0, p1, p2}, 64'd0);
        end else begin
            chk("in_ready_rule", {61'd0, rdy0, rdy1, rdy2}, {61'd0, {3{!ov0 || out_ready}}});
            chk("valid_agree", {62'd0, ov1, ov2}, {62'd0, ov0, ov0});
            if (prev_stall) chk("stall_hold", {39'd0, ov0, p0}, {39'd0, 1'b1, prev_p0});
            if (ov0) begin
                if (q.size() == 0) begin
                    fail_now("spurious_out");
                end else begin
                    chk("p0_model", {40'd0, p0}, {40'd0, q[0].e0});
                    chk("p1_model", {48'd0, p1}, {48'd0, q[0].e1});
                    chk("p2_model", {48'd0, p2}, {48'd0, q[0].e2});
                    esat0 |= q[0].c0; esat1 |= q[0].c1; esat2 |= q[0].c2;
                    if (out_ready) begin
                        log0.push_back(p0);
                        void'(q.pop_front());
                    end
                end
            end
`ifdef PP_MUL_PIPE_SAT_EN
            chk("sat_flags", {61'd0, sf0, sf1, sf2}, {61'd0, esat0, esat1, esat2});
`endif
            prev_stall = ov0 && !out_ready;
            prev_p0    = p0;
            if (in_valid && rdy0) begin
                beat_t       e;
                logic [63:0] t;
                bit          c;
                t = mdl(in_a, in_b, in_mode, 0, 24, c); e.e0 = t[23:0]; e.c0 = c;
                t = mdl(in_a, in_b, in_mode, 4, 16, c); e.e1 = t[15:0]; e.c1 = c;
                t = mdl(in_a, in_b, in_mode, 0, 16, c); e.e2 = t[15:0]; e.c2 = c;
                q.push_back(e);
                acc_cnt++;
            end
        end
    end

    // Drivers are called at posedge+1 and return at posedge+1 after acceptance.
    task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [1:0] m);
        int budget;
        budget   = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_mode  = m;
        @(negedge ap_clk);
        while (!rdy0 && budget < 50) begin
            budget++;
            @(negedge ap_clk);
        end
        if (!rdy0) fail_now("send_timeout");
        @(posedge ap_clk);
        #1;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge ap_clk);
            lat++;
        end while (!ov0 && lat < 30);
        if (!ov0) fail_now("wait_out_timeout");
    endtask

    task automatic one(input logic [11:0] a, input logic [11:0] b, input logic [1:0] m,
                       output int lat);
        send(a, b, m);
        in_valid = 1'b0;
        wait_out(lat);
    endtask

    initial begin
        int lat;
        int budget;
        int base;

        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("rst_in_ready", {63'd0, rdy0}, 64'd1);
        @(posedge ap_clk);
        #1;

        // Directed literal cases.
        one(12'hFFF, 12'hFFF, 2'b00, lat);
        chk("lat_ffx", 64'(lat), 64'(NS));
        chk("p_ffx", {40'd0, p0}, 64'hFFE001);
        @(posedge ap_clk); #1;
        one(12'h000, 12'h123, 2'b00, lat);
        chk("p_zero", {40'd0, p0}, 64'h0);
        @(posedge ap_clk); #1;
        one(12'h800, 12'h001, 2'b11, lat);
        chk("p_neg2048", {40'd0, p0}, 64'hFFF800);
        @(posedge ap_clk); #1;
        one(12'hFFF, 12'hFFF, 2'b01, lat);
        chk("p_mixed", {40'd0, p0}, 64'hFFF001);
        @(posedge ap_clk); #1;
        one(12'h0F8, 12'h001, 2'b00, lat);
        chk("round_up", {48'd0, p1}, 64'd16);
        chk("round_up_p0", {40'd0, p0}, 64'd248);
        @(posedge ap_clk); #1;
        one(12'h0F7, 12'h001, 2'b00, lat);
        chk("round_down", {48'd0, p1}, 64'd15);
        @(posedge ap_clk); #1;
        one(12'h7FF, 12'h7FF, 2'b11, lat);
`ifdef PP_MUL_PIPE_SAT_EN
        chk("sat_p16", {48'd0, p2}, 64'h7FFF);
        chk("sat_flag16", {63'd0, sf2}, 64'd1);
`else
        chk("wrap_p16", {48'd0, p2}, 64'hF001);
`endif
        @(posedge ap_clk); #1;

        // Back-to-back stream with a downstream stall.
        log0.delete();
        base = acc_cnt;
        fork
            begin
                for (int i = 0; i < 16; i++) send(12'(i), 12'd3, 2'b00);
                in_valid = 1'b0;
            end
            begin
                budget = 0;
                while (acc_cnt < base + 6 && budget < 100) begin
                    budget++;
                    @(negedge ap_clk);
                end
                @(posedge ap_clk); #1;
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge ap_clk);
                    chk("stall_in_ready", {62'd0, rdy0, ov0}, 64'd1);
                    @(posedge ap_clk);
                end
                #1;
                out_ready = 1'b1;
            end
        join
        budget = 0;
        while (log0.size() < 16 && budget < 100) begin
            budget++;
            @(negedge ap_clk);
        end
        chk("stream_count", 64'(log0.size()), 64'd16);
        for (int i = 0; i < 16 && i < log0.size(); i++) chk("stream_val", {40'd0, log0[i]}, 64'(3 * i));
        @(posedge ap_clk); #1;

        // Reset with beats in flight.
        for (int i = 0; i < 5; i++) send(12'(i + 1), 12'd5, 2'b00);
        in_valid = 1'b0;
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, ov0}, 64'd0);
        chk("async_rst_p", {40'd0, p0}, 64'd0);
        @(posedge ap_clk); #3;
        ap_rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge ap_clk);
            chk("no_stale", {62'd0, ov0, rdy0}, 64'd1);
        end
        @(posedge ap_clk); #1;
        one(12'h010, 12'h010, 2'b00, lat);
        chk("lat_after_rst", 64'(lat), 64'(NS));
        chk("p_after_rst", {40'd0, p0}, 64'h100);
        @(posedge ap_clk); #1;

        // Randomised traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_mode   = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: in_a = 12'h7FF;
                1: in_a = 12'h800;
                2: in_a = 12'hFFF;
                default: in_a = 12'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: in_b = 12'h7FF;
                1: in_b = 12'h800;
                2: in_b = 12'h000;
                default: in_b = 12'($urandom);
            endcase
            @(posedge ap_clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while (q.size() != 0 && budget < 100) begin
            budget++;
            @(negedge ap_clk);
        end
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
